ttt_move_ctrl: RTL and testbench

Move controller and writer for the 3x3 board of cell storage elements. It accepts player moves over a valid/ready handshake, rejects illegal moves, and drives the per-cell set/symbol/reset lines. It alternates turns and detects win or draw from the cells' valid/symbol read-back. It sits between the player-input front end and the nine cell instances.

---
 rtl/ttt_pkg.sv | 43 ++++
 rtl/ttt_move_ctrl_if.sv | 31 +++
 rtl/ttt_win_detect.sv | 30 +++
 rtl/ttt_move_ctrl.sv | 137 +++++++++++++
 tb/tb_ttt_move_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move controller.
// Board cells are indexed row-major: idx = 3*row + col.
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int IDX_W     = 4;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Three rows, three columns, two diagonals.
    localparam logic [0:7][0:2][IDX_W-1:0] WIN_LINES = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // One-hot cell mask; empty for indices off the board.
    function automatic logic [NUM_CELLS-1:0] cell_mask(
        input logic [IDX_W-1:0] idx
    );
        logic [NUM_CELLS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == IDX_W'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ttt_move_ctrl_if.sv
// Player-move handshake between the input front end and the controller.
// The front end is the master; the controller is the slave.
interface ttt_move_ctrl_if;
    import ttt_pkg::*;

    logic             new_game;
    logic             move_valid;
    logic [IDX_W-1:0] move_idx;
    logic             move_ready;
    logic             move_ack;
    logic             move_err;

    modport master (
        output new_game,
        output move_valid,
        output move_idx,
        input  move_ready,
        input  move_ack,
        input  move_err
    );

    modport slave (
        input  new_game,
        input  move_valid,
        input  move_idx,
        output move_ready,
        output move_ack,
        output move_err
    );

endinterface

// File: rtl/ttt_win_detect.sv
// Combinational line/fullness check over the board read-back.
// Shared with the display/score logic.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [NUM_CELLS-1:0] cell_valid,
    input  logic [NUM_CELLS-1:0] cell_symbol,
    output logic                 win,
    output logic                 win_symbol,
    output logic                 full
);

    // Scan every line for three occupied cells holding one symbol.
    always_comb begin
        win        = 1'b0;
        win_symbol = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (cell_valid[WIN_LINES[l][0]] &&
                cell_valid[WIN_LINES[l][1]] &&
                cell_valid[WIN_LINES[l][2]] &&
                (cell_symbol[WIN_LINES[l][0]] == cell_symbol[WIN_LINES[l][1]]) &&
                (cell_symbol[WIN_LINES[l][1]] == cell_symbol[WIN_LINES[l][2]])) begin
                win        = 1'b1;
                win_symbol = cell_symbol[WIN_LINES[l][0]];
            end
        end
        full = &cell_valid;
    end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Move controller: validates moves, writes cells, alternates turns
// and latches the game result.
module ttt_move_ctrl
    import ttt_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    ttt_move_ctrl_if.slave       mv,
    output logic [NUM_CELLS-1:0] cell_set,
    output logic                 cell_set_symbol,
    output logic                 cell_reset,
    input  logic [NUM_CELLS-1:0] cell_valid,
    input  logic [NUM_CELLS-1:0] cell_symbol,
    output logic                 turn,
    output logic                 game_over,
    output logic                 winner_valid,
    output logic                 winner,
    output logic                 draw
);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic             turn_nx, ack_nx, err_nx;
    logic             over_nx, winv_nx, win_nx, draw_nx;
    logic             win, win_symbol, full, win_now;
    logic             bad_move;

    ttt_win_detect u_win (
        .cell_valid  (cell_valid),
        .cell_symbol (cell_symbol),
        .win         (win),
        .win_symbol  (win_symbol),
        .full        (full)
    );

    // Only the player who just moved can have completed a line.
    assign win_now  = win && (win_symbol == turn);
    assign bad_move = (mv.move_idx >= IDX_W'(NUM_CELLS)) ||
                      (|(cell_valid & cell_mask(mv.move_idx)));

    // Cell strobes; a write never overlaps a clear.
    assign cell_reset      = reset || (state == ST_CLEAR);
    assign cell_set        = (state == ST_WRITE && !reset) ?
                             cell_mask(idx_q) : '0;
    assign cell_set_symbol = (state == ST_WRITE) ? turn : 1'b0;
    assign mv.move_ready   = (state == ST_IDLE);

    // Next-state and next-output decode.
    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        turn_nx  = turn;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        over_nx  = game_over;
        winv_nx  = winner_valid;
        win_nx   = winner;
        draw_nx  = draw;
        unique case (state)
            ST_CLEAR: begin
                turn_nx  = P0;
                over_nx  = 1'b0;
                winv_nx  = 1'b0;
                win_nx   = 1'b0;
                draw_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (mv.new_game) begin
                    state_nx = ST_CLEAR;
                end else if (mv.move_valid) begin
                    if (bad_move) begin
                        err_nx = 1'b1;
                    end else begin
                        idx_nx   = mv.move_idx;
                        state_nx = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                if (win_now) begin
                    winv_nx  = 1'b1;
                    win_nx   = turn;
                    over_nx  = 1'b1;
                    state_nx = ST_DONE;
                end else if (full) begin
                    draw_nx  = 1'b1;
                    over_nx  = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    turn_nx  = ~turn;
                    ack_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (mv.new_game) begin
                    state_nx = ST_CLEAR;
                end else if (mv.move_valid) begin
                    err_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_CLEAR;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_CLEAR;
            idx_q        <= '0;
            turn         <= P0;
            mv.move_ack  <= 1'b0;
            mv.move_err  <= 1'b0;
            game_over    <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
            draw         <= 1'b0;
        end else begin
            state        <= state_nx;
            idx_q        <= idx_nx;
            turn         <= turn_nx;
            mv.move_ack  <= ack_nx;
            mv.move_err  <= err_nx;
            game_over    <= over_nx;
            winner_valid <= winv_nx;
            winner       <= win_nx;
            draw         <= draw_nx;
        end
    end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Directed bench for ttt_move_ctrl with a behavioural model
// of the nine board cells.
module tb_ttt_move_ctrl;
    import ttt_pkg::*;

    logic                 clk;
    logic                 reset;
    logic [NUM_CELLS-1:0] cell_set;
    logic                 cell_set_symbol;
    logic                 cell_reset;
    logic [NUM_CELLS-1:0] cell_valid;
    logic [NUM_CELLS-1:0] cell_symbol;
    logic                 turn;
    logic                 game_over;
    logic                 winner_valid;
    logic                 winner;
    logic                 draw;

    int n_vec  = 0;
    int n_fail = 0;

    ttt_move_ctrl_if mv ();

    ttt_move_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .mv              (mv.slave),
        .cell_set        (cell_set),
        .cell_set_symbol (cell_set_symbol),
        .cell_reset      (cell_reset),
        .cell_valid      (cell_valid),
        .cell_symbol     (cell_symbol),
        .turn            (turn),
        .game_over       (game_over),
        .winner_valid    (winner_valid),
        .winner          (winner),
        .draw            (draw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board cells: clear wins over set.
    always @(posedge clk) begin
        if (cell_reset) begin
            cell_valid  <= '0;
            cell_symbol <= '0;
        end else begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (cell_set[i]) begin
                    cell_valid[i]  <= 1'b1;
                    cell_symbol[i] <= cell_set_symbol;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int idx, input logic sym,
                        input logic ack, input logic over,
                        input logic winv, input logic win,
                        input logic drw, input logic nturn);
        logic [NUM_CELLS-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        mv.move_valid = 1'b1;
        mv.move_idx   = IDX_W'(idx);
        #1;
        chk("ready_idle", 32'(mv.move_ready), 32'd1);
        tick();
        mv.move_valid = 1'b0;
        #1;
        chk("cell_set", 32'(cell_set), 32'(m));
        chk("set_sym", 32'(cell_set_symbol), 32'(sym));
        chk("ready_write", 32'(mv.move_ready), 32'd0);
        tick();
        chk("set_clear", 32'(cell_set), 32'd0);
        chk("ready_check", 32'(mv.move_ready), 32'd0);
        tick();
        chk("ack", 32'(mv.move_ack), 32'(ack));
        chk("err_on_move", 32'(mv.move_err), 32'd0);
        chk("game_over", 32'(game_over), 32'(over));
        chk("winner_valid", 32'(winner_valid), 32'(winv));
        chk("winner", 32'(winner), 32'(win));
        chk("draw", 32'(draw), 32'(drw));
        chk("turn", 32'(turn), 32'(nturn));
    endtask

    task automatic try_bad(input int idx, input logic exp_turn);
        mv.move_valid = 1'b1;
        mv.move_idx   = IDX_W'(idx);
        tick();
        mv.move_valid = 1'b0;
        #1;
        chk("err_pulse", 32'(mv.move_err), 32'd1);
        chk("err_no_ack", 32'(mv.move_ack), 32'd0);
        chk("err_no_set", 32'(cell_set), 32'd0);
        chk("err_turn", 32'(turn), 32'(exp_turn));
        chk("err_ready", 32'(mv.move_ready), 32'd1);
    endtask

    task automatic restart();
        mv.new_game = 1'b1;
        tick();
        mv.new_game = 1'b0;
        #1;
        chk("ng_clear", 32'(cell_reset), 32'd1);
        chk("ng_ready", 32'(mv.move_ready), 32'd0);
        tick();
        chk("ng_idle", 32'(mv.move_ready), 32'd1);
        chk("ng_turn", 32'(turn), 32'd0);
        chk("ng_over", 32'(game_over), 32'd0);
        chk("ng_board", 32'(cell_valid), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        mv.new_game   = 1'b0;
        mv.move_valid = 1'b0;
        mv.move_idx   = '0;

        // Reset for two cycles, then one CLEAR cycle.
        tick();
        chk("rst_cell_reset", 32'(cell_reset), 32'd1);
        chk("rst_ready", 32'(mv.move_ready), 32'd0);
        chk("rst_turn", 32'(turn), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_set", 32'(cell_set), 32'd0);
        chk("rst_ack", 32'(mv.move_ack), 32'd0);
        chk("rst_err", 32'(mv.move_err), 32'd0);
        tick();
        chk("rst_cell_reset2", 32'(cell_reset), 32'd1);
        reset = 1'b0;
        #1;
        chk("clear_cell_reset", 32'(cell_reset), 32'd1);
        tick();
        chk("idle_cell_reset", 32'(cell_reset), 32'd0);
        chk("idle_ready", 32'(mv.move_ready), 32'd1);
        chk("idle_turn", 32'(turn), 32'd0);
        chk("idle_over", 32'(game_over), 32'd0);

        // Centre move, then ack is a single pulse.
        play(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ack_pulse_end", 32'(mv.move_ack), 32'd0);

        // Occupied cell and off-board index.
        try_bad(4, 1'b1);
        try_bad(9, 1'b1);
        tick();
        chk("err_pulse_end", 32'(mv.move_err), 32'd0);
        chk("board_after_err", 32'(cell_valid), 32'h010);

        // P0 takes the top row.
        restart();
        play(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play(2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mv.move_valid = 1'b1;
        mv.move_idx   = 4'd5;
        #1;
        chk("done_ready", 32'(mv.move_ready), 32'd0);
        tick();
        mv.move_valid = 1'b0;
        #1;
        chk("done_err", 32'(mv.move_err), 32'd1);
        chk("done_hold_over", 32'(game_over), 32'd1);
        chk("done_hold_winv", 32'(winner_valid), 32'd1);
        chk("done_no_set", 32'(cell_set), 32'd0);

        // Full board with no line.
        restart();
        play(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play(7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        play(8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during the WRITE cycle abandons the move.
        restart();
        play(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mv.move_valid = 1'b1;
        mv.move_idx   = 4'd1;
        tick();
        mv.move_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rw_no_set", 32'(cell_set), 32'd0);
        chk("rw_cell_reset", 32'(cell_reset), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("rw_clear", 32'(cell_reset), 32'd1);
        chk("rw_no_ack", 32'(mv.move_ack), 32'd0);
        tick();
        chk("rw_idle", 32'(mv.move_ready), 32'd1);
        chk("rw_turn", 32'(turn), 32'd0);
        chk("rw_no_ack2", 32'(mv.move_ack), 32'd0);
        chk("rw_board", 32'(cell_valid), 32'd0);

        // new_game beats a simultaneous move.
        play(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mv.new_game   = 1'b1;
        mv.move_valid = 1'b1;
        mv.move_idx   = 4'd5;
        tick();
        mv.new_game   = 1'b0;
        mv.move_valid = 1'b0;
        #1;
        chk("ngm_clear", 32'(cell_reset), 32'd1);
        chk("ngm_no_err", 32'(mv.move_err), 32'd0);
        chk("ngm_no_set", 32'(cell_set), 32'd0);
        tick();
        chk("ngm_turn", 32'(turn), 32'd0);
        chk("ngm_no_ack", 32'(mv.move_ack), 32'd0);
        chk("ngm_board", 32'(cell_valid), 32'd0);
        chk("ngm_ready", 32'(mv.move_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
